// File: rtl/ps2_key_ctrl.sv
// PS/2 key sequencer: folds E0/F0 prefixes into key events and queues them behind a valid/ready FIFO.
// Optional shift tracking is enabled by defining SHIFT_TRACK_EN.
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ctrl_en,
  input  logic                          rx_done_tick,
  input  logic [7:0]                    rx_dout,
  output logic                          rx_en,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic                          ev_shift,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          timeout_err,
  output logic [1:0]                    state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    P_E0   = 2'd1,
    P_F0   = 2'd2,
    P_E0F0 = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       sh;
  } ev_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            to_clr, to_inc, timeout_nxt;
  logic            push;
  logic            tick_acc, is_e0, is_f0, is_resp, to_hit;
  logic            ev_ext_in, ev_brk_in, shift_cur;

  assign state_dbg = state;
  assign tick_acc  = ctrl_en & rx_done_tick;
  assign is_e0     = (rx_dout == 8'hE0);
  assign is_f0     = (rx_dout == 8'hF0);
  assign is_resp   = (rx_dout == 8'h00) || (rx_dout == 8'hAA) || (rx_dout == 8'hEE) ||
                     (rx_dout == 8'hFA) || (rx_dout == 8'hFC) || (rx_dout == 8'hFF);
  assign to_hit    = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign ev_ext_in = (state == P_E0) || (state == P_E0F0);
  assign ev_brk_in = (state == P_F0) || (state == P_E0F0);

  // A byte arriving on the timeout edge takes priority over the timeout.
  always_comb begin
    state_nxt   = state;
    push        = 1'b0;
    to_clr      = 1'b0;
    to_inc      = 1'b0;
    timeout_nxt = 1'b0;
    if (!ctrl_en) begin
      state_nxt = IDLE;
      to_clr    = 1'b1;
    end else if (tick_acc) begin
      to_clr = 1'b1;
      if (is_e0) begin
        state_nxt = P_E0;
      end else if (is_f0) begin
        case (state)
          IDLE:    state_nxt = P_F0;
          P_E0:    state_nxt = P_E0F0;
          default: state_nxt = state;
        endcase
      end else if (is_resp) begin
        state_nxt = IDLE;
      end else begin
        push      = 1'b1;
        state_nxt = IDLE;
      end
    end else if (state != IDLE) begin
      if (to_hit) begin
        state_nxt   = IDLE;
        to_clr      = 1'b1;
        timeout_nxt = 1'b1;
      end else begin
        to_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
      rx_en       <= 1'b0;
    end else begin
      state       <= state_nxt;
      timeout_err <= timeout_nxt;
      rx_en       <= ctrl_en;
      if (to_clr)      to_cnt <= '0;
      else if (to_inc) to_cnt <= to_cnt + TO_W'(1);
    end
  end

`ifdef SHIFT_TRACK_EN
  logic shl, shr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shl <= 1'b0;
      shr <= 1'b0;
    end else if (push && !ev_ext_in) begin
      if (rx_dout == 8'h12) shl <= ~ev_brk_in;
      if (rx_dout == 8'h59) shr <= ~ev_brk_in;
    end
  end

  assign shift_cur = shl | shr;
`else
  assign shift_cur = 1'b0;
`endif

  // Handshake: ev_valid means the head entry is present; it is consumed at a
  // rising edge where ev_valid & ev_ready, and ev_* hold while ready is low.
  ev_t            mem [FIFO_DEPTH];
  ev_t            head;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           full, do_pop, do_write;

  assign full     = (fifo_count == CW'(FIFO_DEPTH));
  assign ev_valid = (fifo_count != '0);
  assign do_pop   = ev_valid & ev_ready;
  assign do_write = push & (~full | do_pop);
  assign head     = mem[rd_ptr];

  assign ev_code  = ev_valid ? head.code : 8'h00;
  assign ev_ext   = ev_valid & head.ext;
  assign ev_break = ev_valid & head.brk;
  assign ev_shift = ev_valid & head.sh;

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= '{code: rx_dout, ext: ev_ext_in, brk: ev_brk_in, sh: shift_cur};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= push & full & ~do_pop;
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({do_write, do_pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: event-queue model checked every cycle plus directed literal checks.
module tb_ps2_key_ctrl;

  localparam int DEPTH = 4;
  localparam int T     = 20;
  localparam int TOW   = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ctrl_en = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_dout = 8'h00;
  logic       ev_ready = 1'b0;
  logic       rx_en, ev_valid, ev_ext, ev_break, ev_shift, overflow, timeout_err;
  logic [7:0] ev_code;
  logic [2:0] fifo_count;
  logic [1:0] state_dbg;

  ps2_key_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(T), .TO_W(TOW)) dut (
    .clk(clk), .reset(reset), .ctrl_en(ctrl_en), .rx_done_tick(rx_done_tick),
    .rx_dout(rx_dout), .rx_en(rx_en), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break), .ev_shift(ev_shift),
    .fifo_count(fifo_count), .overflow(overflow), .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected queue entries are {sh, brk, ext, code}.
  logic [10:0] exp_q[$];
  logic        m_pend, m_ext_p, m_brk_p, m_shl, m_shr;
  logic        m_ovf, m_to, m_rx_en, m_pop, m_full, m_have;
  logic [10:0] m_ev;
  int          m_wait;

  initial begin
    m_pend = 0; m_ext_p = 0; m_brk_p = 0; m_shl = 0; m_shr = 0;
    m_ovf = 0; m_to = 0; m_rx_en = 0; m_wait = 0;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      m_pend = 0; m_ext_p = 0; m_brk_p = 0; m_shl = 0; m_shr = 0;
      m_ovf = 0; m_to = 0; m_rx_en = 0; m_wait = 0;
    end else begin
      m_ovf  = 0;
      m_to   = 0;
      m_have = 0;
      m_ev   = '0;
      m_pop  = (exp_q.size() != 0) && ev_ready;
      m_full = (exp_q.size() == DEPTH);
      if (!ctrl_en) begin
        m_pend = 0; m_ext_p = 0; m_brk_p = 0; m_wait = 0;
      end else if (rx_done_tick) begin
        m_wait = 0;
        if (rx_dout == 8'hE0) begin
          m_pend = 1; m_ext_p = 1; m_brk_p = 0;
        end else if (rx_dout == 8'hF0) begin
          m_pend = 1; m_brk_p = 1;
        end else if (rx_dout inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFF}) begin
          m_pend = 0; m_ext_p = 0; m_brk_p = 0;
        end else begin
`ifdef SHIFT_TRACK_EN
          m_ev = {m_shl | m_shr, m_brk_p, m_ext_p, rx_dout};
          if (!m_ext_p && rx_dout == 8'h12) m_shl = !m_brk_p;
          if (!m_ext_p && rx_dout == 8'h59) m_shr = !m_brk_p;
`else
          m_ev = {1'b0, m_brk_p, m_ext_p, rx_dout};
`endif
          m_have = 1;
          m_pend = 0; m_ext_p = 0; m_brk_p = 0;
        end
      end else if (m_pend) begin
        if (m_wait == T - 1) begin
          m_to = 1; m_wait = 0;
          m_pend = 0; m_ext_p = 0; m_brk_p = 0;
        end else begin
          m_wait++;
        end
      end
      m_rx_en = ctrl_en;
      if (m_pop) void'(exp_q.pop_front());
      if (m_have) begin
        if (m_full && !m_pop) m_ovf = 1;
        else exp_q.push_back(m_ev);
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("rx_en", rx_en, m_rx_en);
      chk("ev_valid", ev_valid, exp_q.size() != 0);
      chk("fifo_count", fifo_count, exp_q.size());
      chk("overflow", overflow, m_ovf);
      chk("timeout_err", timeout_err, m_to);
      if (exp_q.size() != 0) begin
        chk("ev_code", ev_code, exp_q[0][7:0]);
        chk("ev_ext", ev_ext, exp_q[0][8]);
        chk("ev_break", ev_break, exp_q[0][9]);
        chk("ev_shift", ev_shift, exp_q[0][10]);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_done_tick = 1'b1;
    rx_dout      = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
    rx_dout      = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop1();
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  logic [7:0] exp3[4];
  int         pulses;

  initial begin
    // reset state
    #12;
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_rx_en", rx_en, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_state", state_dbg, 0);
    @(negedge clk);
    reset = 1'b1;
    ctrl_en = 1'b1;
    idle(1);
    chk("rx_en_on", rx_en, 1);

    // single make code
    send(8'h1C);
    chk("t1_valid", ev_valid, 1);
    chk("t1_code", ev_code, 8'h1C);
    chk("t1_ext", ev_ext, 0);
    chk("t1_brk", ev_break, 0);
    chk("t1_count", fifo_count, 1);
    pop1();
    chk("t1_count_pop", fifo_count, 0);

    // break and extended break
    send(8'hF0);
    chk("t2_f0_noev", fifo_count, 0);
    send(8'h1C);
    chk("t2_code", ev_code, 8'h1C);
    chk("t2_brk", ev_break, 1);
    chk("t2_ext", ev_ext, 0);
    pop1();
    send(8'hE0);
    send(8'hF0);
    chk("t2_pfx_noev", fifo_count, 0);
    send(8'h75);
    chk("t2_code2", ev_code, 8'h75);
    chk("t2_ext2", ev_ext, 1);
    chk("t2_brk2", ev_break, 1);
    pop1();

    // overflow on a full FIFO
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    chk("t3_full", fifo_count, 4);
    chk("t3_no_ovf", overflow, 0);
    send(8'h2C);
    chk("t3_ovf", overflow, 1);
    chk("t3_count", fifo_count, 4);
    idle(1);
    chk("t3_ovf_pulse", overflow, 0);
    idle(2);
    chk("t3_stable", ev_code, 8'h15);
    exp3 = '{8'h15, 8'h1D, 8'h24, 8'h2D};
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", ev_code, exp3[i]);
      pop1();
    end
    chk("t3_empty", fifo_count, 0);

    // full FIFO with simultaneous pop and push
    send(8'h1A); send(8'h1B); send(8'h21); send(8'h22);
    ev_ready = 1'b1;
    send(8'h23);
    ev_ready = 1'b0;
    chk("full_pp_count", fifo_count, 4);
    chk("full_pp_ovf", overflow, 0);
    chk("full_pp_head", ev_code, 8'h1B);
    ev_ready = 1'b1;
    idle(4);
    ev_ready = 1'b0;
    chk("full_pp_drain", fifo_count, 0);

    // timeout after a lone prefix
    send(8'hE0);
    pulses = 0;
    repeat (T + 5) begin
      @(negedge clk);
      if (timeout_err) pulses++;
    end
    chk("t4_pulses", pulses, 1);
    chk("t4_state", state_dbg, 0);
    chk("t4_noev", fifo_count, 0);
    send(8'h74);
    chk("t4_code", ev_code, 8'h74);
    chk("t4_ext", ev_ext, 0);
    pop1();

    // byte arriving on the timeout edge wins
    send(8'hE0);
    idle(T - 1);
    send(8'h6C);
    chk("to_edge_err", timeout_err, 0);
    chk("to_edge_code", ev_code, 8'h6C);
    chk("to_edge_ext", ev_ext, 1);
    pop1();
    // one cycle later the timeout fires
    send(8'hE0);
    idle(T);
    chk("to_exact", timeout_err, 1);
    idle(1);
    chk("to_exact_off", timeout_err, 0);

    // device response and disable mid-sequence
    send(8'hFA);
    chk("t5_fa_noev", fifo_count, 0);
    send(8'hE0);
    ctrl_en = 1'b0;
    idle(1);
    chk("t5_rx_en_off", rx_en, 0);
    send(8'h6B);
    chk("t5_ignored", fifo_count, 0);
    chk("t5_rx_en", rx_en, 0);
    ctrl_en = 1'b1;
    idle(1);
    send(8'h6B);
    chk("t5_code", ev_code, 8'h6B);
    chk("t5_ext", ev_ext, 0);
    pop1();

`ifdef SHIFT_TRACK_EN
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    chk("t6_count", fifo_count, 4);
    chk("t6_c0", ev_code, 8'h12); chk("t6_s0", ev_shift, 0); pop1();
    chk("t6_c1", ev_code, 8'h1C); chk("t6_s1", ev_shift, 1); pop1();
    chk("t6_c2", ev_code, 8'h12); chk("t6_b2", ev_break, 1); chk("t6_s2", ev_shift, 1); pop1();
    chk("t6_c3", ev_code, 8'h1C); chk("t6_s3", ev_shift, 0); pop1();
`else
    send(8'h12); send(8'h1C);
    chk("t6_shift_off", ev_shift, 0);
    pop1(); pop1();
`endif

    // asynchronous reset with data in the FIFO
    send(8'h29); send(8'h2A);
    chk("t6_pre_rst", fifo_count, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_valid", ev_valid, 0);
    chk("t6_rst_rx_en", rx_en, 0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    send(8'h1C);
    chk("post_rst_code", ev_code, 8'h1C);
    pop1();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
